// File: rtl/cpu_step_ctrl.sv
// ============================================================================
//  cpu_step_ctrl : step sequencer, write-port FIFO and interrupt latch
//  Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl #(
  parameter int PHASES   = 4,
  parameter int DW       = 32,
  parameter int WQ_DEPTH = 2,
  parameter int NIRQ     = 4,
  localparam int PW      = $clog2(PHASES),
  localparam int IW      = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PW-1:0]   phase,
  output logic            step_en,
  input  logic            wr_want,
  input  logic [DW-1:0]   wr_data,
  output logic            w_req,
  output logic [DW-1:0]   w_data,
  input  logic            w_busy,
  input  logic [NIRQ-1:0] irr,
  output logic            irq_valid,
  output logic [IW-1:0]   irq_id,
  input  logic            irq_take,
  output logic [NIRQ-1:0] ack
);

  localparam int CW = $clog2(WQ_DEPTH + 1);
  localparam int AW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PH  = PW'(PHASES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WQ_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(WQ_DEPTH - 1);

  logic [PW-1:0]   r_phase;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [DW-1:0]   r_mem [WQ_DEPTH];
  logic [NIRQ-1:0] r_irr_q;
  logic [NIRQ-1:0] r_pend;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_stall;
  logic            w_ack_en;
  logic [NIRQ-1:0] w_rise;
  logic [IW-1:0]   w_irq_id;
  logic [NIRQ-1:0] w_ack;

  assign w_full   = (r_count == FULL_CNT);
  assign w_req    = (r_count != '0);
  assign w_pop    = w_req & ~w_busy;
  // A pop in the same cycle frees the slot, so a full FIFO need not stall.
  assign w_stall  = wr_want & w_full & ~w_pop;
  assign step_en  = (r_phase == LAST_PH) & ~w_stall;
  assign w_push   = step_en & wr_want;
  assign w_rise   = irr & ~r_irr_q;
  assign w_ack_en = step_en & irq_take & irq_valid;

  assign phase     = r_phase;
  assign w_data    = w_req ? r_mem[r_rptr] : '0;
  assign irq_valid = |r_pend;
  assign irq_id    = w_irq_id;
  assign ack       = w_ack;

  always_comb begin
    w_irq_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (r_pend[i]) w_irq_id = IW'(i);
    end
  end

  always_comb begin
    w_ack = '0;
    if (w_ack_en) w_ack[w_irq_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase <= '0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_irr_q <= '0;
      r_pend  <= '0;
    end else begin
      if (r_phase == LAST_PH) begin
        if (!w_stall) r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end

      if (w_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      r_irr_q <= irr;
      // A new edge outranks a clear landing on the same channel.
      r_pend  <= (r_pend & ~w_ack) | w_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Parametrised step sequencer and I/O handshake unit for the multi-cycle CPU core. It generates the phase count and the per-instruction commit strobe (`step_en`) for the register files and ALU. It buffers core write requests in a small FIFO drained over a `w_req`/`w_busy` handshake, stalling commit only when that buffer cannot accept. It also latches prioritised interrupt requests and issues one-hot acknowledges at commit.

## Interface
- `PHASES`, default 4: clock phases per instruction step; at least 2.
- `DW`, default 32: width of write data.
- `WQ_DEPTH`, default 2: write FIFO entries; at least 1.
- `NIRQ`, default 4: interrupt request channels; at least 1. Channel 0 has the highest priority.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `phase`  out  $clog2(PHASES)  current phase, 0..PHASES-1.
- `step_en`  out  1  commit strobe; the register files write only when it is high.
- `wr_want`  in  1  the current instruction writes to the output port; valid during the whole step.
- `wr_data`  in  DW  data for that write; sampled on the `step_en` cycle.
- `w_req`  out  1  FIFO non-empty; head entry is offered downstream.
- `w_data`  out  DW  FIFO head entry; equals 0 when the FIFO is empty.
- `w_busy`  in  1  downstream is not accepting.
- `irr`  in  NIRQ  level interrupt requests, one per channel.
- `irq_valid`  out  1  at least one interrupt is pending.
- `irq_id`  out  $clog2(NIRQ) (min 1)  index of the lowest pending channel; 0 when none is pending.
- `irq_take`  in  1  the core vectors to the interrupt at this commit.
- `ack`  out  NIRQ  one-hot acknowledge for the taken channel.

## Operation
- **Phase counter**
  - Counts 0 → PHASES-1, then wraps to 0.
  - Holds at PHASES-1 while `stall` is high.
- **Stall and commit**
  - `stall = wr_want & full & ~pop`.
  - `step_en = (phase == PHASES-1) & ~stall`. It is combinational from registered state and inputs.
- **Write FIFO**
  - Push when `step_en & wr_want`, storing `wr_data`.
  - Pop when `w_req & ~w_busy`. One word transfers in every such cycle.
  - Push and pop in the same cycle: count is unchanged. This is legal at full, because the pop frees the slot, and at empty with count 0→1→0, which is not possible since `w_req` is low when empty.
  - Count width is $clog2(WQ_DEPTH+1); read and write pointers wrap modulo WQ_DEPTH.
  - `w_data` is stable while `w_req & w_busy`.
- **Interrupts**
  - `irr_q` registers `irr`. A rising edge (`irr & ~irr_q`) sets `pend[i]`.
  - `irq_valid = |pend`; `irq_id` is the lowest set index.
  - `ack = onehot(irq_id)` when `step_en & irq_take & irq_valid`, and 0 otherwise.
  - `irq_take` without `irq_valid` is ignored.
  - `pend` next value = `(pend & ~ack) | rise`. When a set and a clear hit the same channel in the same cycle, the set wins.
- **Reset** (`reset_n` low at a clock edge), effective the same edge:
  - `phase` = 0.
  - FIFO emptied, so `w_req` = 0 and `w_data` = 0.
  - `pend` = 0 and `irr_q` = 0.
  - Consequently `step_en` = 0, `ack` = 0, `irq_valid` = 0, `irq_id` = 0.
  - Reset in the middle of a transfer drops all buffered data with no handshake.
  - A held-high `irr` at reset release registers as a rise on the first clock after release.

## Timing
- **Step period:** PHASES cycles with no stall; `step_en` is high exactly one cycle per step.
- **Commit:** the first `step_en` after reset release occurs at cycle PHASES-1, counting the first post-reset edge as cycle 0.
- **Write latency:** a push at cycle t gives `w_req` = 1 at t+1. With `w_busy` low, the word transfers at t+1.
- **Stall exit:** a stall lasts until a pop occurs. `step_en` asserts in the pop cycle itself.
- **Interrupt latency:** an `irr` edge sampled at t gives `irq_valid` at t+1.
  - `ack` is a single-cycle pulse coincident with `step_en`.
  - The cleared `pend` bit is visible at the next cycle.
- **Combinational paths:** `step_en` and `ack` depend combinationally on `wr_want`, `w_busy` and `irq_take`. No other output has an input-to-output combinational path.

## Test plan
- **Free run.** Defaults, `wr_want`=0, no `irr`. `phase` must cycle 0,1,2,3. `step_en` must be high at cycles 3, 7, 11. All other outputs must stay 0.
- **Write stream.** `wr_want`=1 every step, `wr_data` = step index, `w_busy`=0. Expect `w_req` pulses one cycle after each `step_en`, with `w_data` = 0,1,2,… in order. No stall.
- **Back-pressure.** `w_busy`=1 held, `wr_want`=1. The first 2 steps commit. The 3rd holds `phase`=3 with `step_en`=0 and `w_data` frozen at 0. Drop `w_busy` for one cycle: `step_en` must be high that cycle, then words 1 and 2 drain in order.
- **Interrupt priority.** Raise `irr`=4'b1010; then `irq_valid`=1 and `irq_id`=1. With `irq_take`=1 at the next `step_en`, `ack` must be 4'b0010. Then `irq_id`=3, and the next take gives `ack` = 4'b1000. Afterwards `irq_valid`=0.
- **Set/clear collision.** Pulse `irr[0]` low then high so its rising edge lands on the cycle of `ack[0]`. `pend[0]` must remain set, i.e. `irq_valid`=1 with `irq_id`=0 on the next cycle.
- **Reset mid-operation.** FIFO holding 2 words, `w_busy`=1, `pend`=4'b0100. Assert `reset_n`=0 for one cycle. On the next cycle, `w_req`, `w_data`, `irq_valid`, `phase`, `ack` and `step_en` must all be 0.
